// File: rtl/wb_arbiter.sv
// Write-back arbiter: load/ALU results go through a fixed-priority arbiter into
// a small FIFO, which feeds a registered register-file write port.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [AW-1:0]         alu_addr,
  input  logic [DW-1:0]         alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DW-1:0]         ld_data,
  output logic                  ld_ready,
  input  logic                  wb_hold,
  output logic [AW-1:0]         wb_addr,
  output logic [DW-1:0]         wb_data,
  output logic                  wb_we_n,
  output logic [(1<<AW)-1:0]    pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_n_q, we_n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;

  // Readiness looks only at registered occupancy, never at a same-cycle pop.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    ld_ready  = rst && !full;
    alu_ready = rst && !full && !ld_valid;
    push      = (ld_valid && ld_ready) || (alu_valid && alu_ready);
    push_addr = ld_valid ? ld_addr : alu_addr;
    push_data = ld_valid ? ld_data : alu_data;
    pop       = rst && !wb_hold && (count_q != '0);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    we_n_d = !pop;
    addr_d = pop ? mem_addr_q[rd_ptr_q] : addr_q;
    data_d = pop ? mem_data_q[rd_ptr_q] : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_n_q   <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_n_q   <= we_n_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= push_addr;
      mem_data_q[wr_ptr_q] <= push_data;
    end
  end

  // Valid FIFO entries are the count_q slots starting at the read pointer.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) pending[mem_addr_q[rd_ptr_q + PW'(i)]] = 1'b1;
    end
    if (!we_n_q) pending[addr_q] = 1'b1;
  end

  assign wb_we_n = we_n_q;
  assign wb_addr = addr_q;
  assign wb_data = data_q;
  assign count   = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, priority, hold, streaming order,
// mid-operation reset and full-FIFO acceptance.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wb_hold;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_we_n;
  logic [15:0] pending;
  logic [2:0]  count;

  wb_arbiter #(.DEPTH(4), .AW(4), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .wb_hold(wb_hold), .wb_addr(wb_addr), .wb_data(wb_data), .wb_we_n(wb_we_n),
    .pending(pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [35:0] log_q[$];
  int          log_cyc[$];
  logic [35:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wb_we_n === 1'b0) begin
      log_q.push_back({wb_addr, wb_data});
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    log_q.delete();
    log_cyc.delete();
    exp_q.delete();
  endtask

  task automatic send(input bit is_ld, input logic [3:0] a, input logic [31:0] d);
    bit r;
    r = 1'b0;
    if (is_ld) begin ld_valid = 1'b1; ld_addr = a; ld_data = d; end
    else       begin alu_valid = 1'b1; alu_addr = a; alu_data = d; end
    for (int n = 0; n < 50 && !r; n++) begin
      @(negedge clk);
      r = is_ld ? ld_ready : alu_ready;
      @(posedge clk);
      #1;
    end
    if (is_ld) ld_valid = 1'b0; else alu_valid = 1'b0;
    if (!r) check("send_timeout", 64'(r), 64'd1);
    else exp_q.push_back({a, d});
  endtask

  task automatic verify_log(input string tag, input bit contiguous);
    int n;
    check({tag, "_nwrites"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_wr%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
      if (contiguous && i > 0)
        check($sformatf("%s_gap%0d", tag, i), 64'(log_cyc[i] - log_cyc[i-1]), 64'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; wb_hold = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state
    tick(); tick();
    alu_valid = 1'b1;
    #1;
    check("rst_we_n", 64'(wb_we_n), 64'd1);
    check("rst_addr", 64'(wb_addr), 64'd0);
    check("rst_data", 64'(wb_data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_ld_ready", 64'(ld_ready), 64'd0);
    alu_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Single ALU write: 2-cycle latency, one-cycle strobe
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h1234;
    #1;
    check("t1_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check("t1_count_e", 64'(count), 64'd1);
    check("t1_we_n_e", 64'(wb_we_n), 64'd1);
    check("t1_pend_e", 64'(pending), 64'h0008);
    tick();
    check("t1_we_n_w", 64'(wb_we_n), 64'd0);
    check("t1_addr_w", 64'(wb_addr), 64'd3);
    check("t1_data_w", 64'(wb_data), 64'h1234);
    check("t1_pend_w", 64'(pending), 64'h0008);
    check("t1_count_w", 64'(count), 64'd0);
    tick();
    check("t1_we_n_after", 64'(wb_we_n), 64'd1);
    check("t1_pend_after", 64'(pending), 64'd0);
    check("t1_addr_hold", 64'(wb_addr), 64'd3);

    // Same-address load and ALU in one cycle: load first, ALU value final
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 32'hAAAA;
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h5555;
    #1;
    check("t2_ld_ready", 64'(ld_ready), 64'd1);
    check("t2_alu_ready0", 64'(alu_ready), 64'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    check("t2_alu_ready1", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check("t2_we_n1", 64'(wb_we_n), 64'd0);
    check("t2_wr1", 64'({wb_addr, wb_data}), 64'({4'd5, 32'hAAAA}));
    check("t2_pend1", 64'(pending), 64'h0020);
    tick();
    check("t2_we_n2", 64'(wb_we_n), 64'd0);
    check("t2_wr2", 64'({wb_addr, wb_data}), 64'({4'd5, 32'h5555}));
    check("t2_pend2", 64'(pending), 64'h0020);
    tick();
    check("t2_we_n3", 64'(wb_we_n), 64'd1);
    check("t2_pend3", 64'(pending), 64'd0);

    // Hold with six ALU results offered
    clear_logs();
    wb_hold = 1'b1;
    fork
      for (int k = 1; k <= 6; k++) send(1'b0, 4'(k), 32'h100 + 32'(k));
      begin
        repeat (8) @(posedge clk);
        #2;
        check("t3_count_full", 64'(count), 64'd4);
        check("t3_alu_ready_full", 64'(alu_ready), 64'd0);
        check("t3_we_n_held", 64'(wb_we_n), 64'd1);
        check("t3_pend_full", 64'(pending), 64'h001E);
        check("t3_nolog_held", 64'(log_q.size()), 64'd0);
        wb_hold = 1'b0;
      end
    join
    repeat (4) tick();
    verify_log("t3", 1'b1);

    // Streaming 20 alternating results
    clear_logs();
    for (int i = 0; i < 20; i++) send(i[0] == 1'b0, 4'(i), 32'hC000 + 32'(i));
    repeat (3) tick();
    verify_log("t4", 1'b1);
    check("t4_count_end", 64'(count), 64'd0);

    // Reset mid-operation with count=3 and a write issuing
    clear_logs();
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 4'(8 + i), 32'hD000 + 32'(i));
    wb_hold = 1'b0;
    tick();
    check("t5_count_pre", 64'(count), 64'd3);
    check("t5_we_n_pre", 64'(wb_we_n), 64'd0);
    rst = 1'b0;
    ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 32'hEEEE;
    #1;
    check("t5_ld_ready_rst", 64'(ld_ready), 64'd0);
    tick();
    check("t5_we_n_rst", 64'(wb_we_n), 64'd1);
    check("t5_count_rst", 64'(count), 64'd0);
    check("t5_pend_rst", 64'(pending), 64'd0);
    check("t5_ld_ready_rst2", 64'(ld_ready), 64'd0);
    check("t5_wr_rst", 64'({wb_addr, wb_data}), 64'd0);
    ld_valid = 1'b0;
    clear_logs();
    rst = 1'b1;
    repeat (4) tick();
    check("t5_no_stale", 64'(log_q.size()), 64'd0);
    check("t5_count_after", 64'(count), 64'd0);

    // Full FIFO with same-cycle pop: no accept until the next cycle
    clear_logs();
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 4'(10 + i), 32'hF000 + 32'(i));
    check("t6_count4a", 64'(count), 64'd4);
    wb_hold = 1'b0;
    ld_valid = 1'b1; ld_addr = 4'd9; ld_data = 32'h9999;
    #1;
    check("t6_ld_ready_full", 64'(ld_ready), 64'd0);
    tick();
    check("t6_count3", 64'(count), 64'd3);
    check("t6_ld_ready_free", 64'(ld_ready), 64'd1);
    wb_hold = 1'b1;
    tick();
    check("t6_count4b", 64'(count), 64'd4);
    ld_valid = 1'b0;
    exp_q.push_back({4'd9, 32'h9999});
    wb_hold = 1'b0;
    repeat (7) tick();
    verify_log("t6", 1'b0);
    check("t6_pend_end", 64'(pending), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back stage that sits directly upstream of the register file's write port. It drives the register file's write address, write data and active-low write enable.
- Accepts results from two producers, the ALU/filter datapath and the load path, each with a valid/ready handshake.
- Arbitrates between them, buffers accepted results in a small FIFO and issues at most one register write per cycle.
- Exports a pending-write mask so the operand-fetch logic can detect read-after-write hazards.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- AW, 4, register address width (16 registers).
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- alu_valid  in  1  ALU result present.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid&alu_ready.
- ld_valid  in  1  load result present.
- ld_addr  in  AW  load destination register.
- ld_data  in  DW  load data.
- ld_ready  out  1  load result accepted when ld_valid&ld_ready.
- wb_hold  in  1  high = freeze write issue (debug/stall); FIFO may still fill.
- wb_addr  out  AW  register file write address.
- wb_data  out  DW  register file write data.
- wb_we_n  out  1  register file write enable, active-low, one cycle per write.
- pending  out  16  bit i set if a write to register i is buffered or being issued.
- count  out  3  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO emptied, count=0, output stage invalid.
  - wb_we_n=1, wb_addr=0, wb_data=0, pending=0.
  - alu_ready=0 and ld_ready=0 while rst=0.
  - Reset mid-operation discards all buffered and in-flight writes; no write is issued in the cycle after reset.
- Arbitration (combinational):
  - When the FIFO is not full, load has fixed priority: ld_ready=1; alu_ready = !ld_valid.
  - When full (count==DEPTH): both readies = 0.
  - Readiness does not depend on a same-cycle dequeue, so full means no accept even when a pop occurs.
  - At most one enqueue per cycle.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Enqueue and pop in the same cycle leave count unchanged.
  - count never exceeds DEPTH or underflows.
  - Order is preserved: writes reach the register file in acceptance order.
- Output stage (registered):
  - At each posedge with wb_hold=0 and FIFO non-empty, the head is popped into wb_addr/wb_data and wb_we_n=0 for the following cycle.
  - With FIFO empty or wb_hold=1: wb_we_n=1, and wb_addr/wb_data hold their last values.
  - Sustained throughput is 1 write/cycle.
  - Latency: a result accepted at posedge E drives wb_we_n=0 in the cycle after posedge E+1, i.e. 2 cycles minimum.
  - wb_we_n is stable for a full cycle, so the register file may sample it on negedge.
- wb_hold:
  - A hold asserted during an issue cycle does not cancel that write; it blocks the next pop.
  - Deasserting hold resumes issue on the next posedge.
- pending:
  - OR of decoded addresses of all valid FIFO entries plus the output stage while wb_we_n=0.
  - Combinational from registered state.
  - Duplicate addresses in the FIFO keep the bit set until the last such write issues.
- Same-address writes from both sources in one cycle: load is accepted, ALU waits, then ALU writes after, so the ALU value is final.

Test Plan:
- Reset then single ALU write (alu_addr=3, alu_data=0x1234) -> alu_ready=1; wb_we_n=0 exactly one cycle, two cycles later with wb_addr=3, wb_data=0x1234; pending[3] set for 2 cycles then clear.
- Simultaneous ld_valid (addr 5, 0xAAAA) and alu_valid (addr 5, 0x5555) -> alu_ready=0 first cycle; writes issue load then ALU on consecutive cycles; pending[5] clears only after the second.
- wb_hold=1 with 6 ALU results offered back-to-back -> 4 accepted, count=4, alu_ready=0; release hold -> 4 writes in order on 4 consecutive cycles; remaining 2 accepted as space frees.
- Streaming 20 alternating ld/alu results with hold=0 -> 1 write/cycle, correct order, count wraps pointers with no loss or duplication.
- rst=0 asserted with count=3 and a write issuing -> next cycle wb_we_n=1, count=0, pending=0, readies 0; no stale write after rst=1.
- Full FIFO with pop in same cycle and ld_valid=1 -> ld_ready=0 that cycle, accepted next cycle; count goes 4->3->4.
